// File: rtl/hs_join_rx_sync_if.sv
// Receive-side bundle of the join channels: 4-phase requests/acks with bundled data bits,
// plus the valid/ready read port and occupancy of the joined-word FIFO.
interface hs_join_rx_sync_if #(
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 4
);
    logic [N_CH-1:0]              rr;
    logic [N_CH-1:0]              dat;
    logic [N_CH-1:0]              ra;
    logic                         o_valid;
    logic [N_CH-1:0]              o_data;
    logic                         i_ready;
    logic [$clog2(FIFO_DEPTH):0]  o_count;

    modport slave (
        input  rr, dat, i_ready,
        output ra, o_valid, o_data, o_count
    );

    modport master (
        output rr, dat, i_ready,
        input  ra, o_valid, o_data, o_count
    );
endinterface

// File: rtl/hs_join_rx_sync.sv
// Clocked receiver for N_CH asynchronous 4-phase bundled-data channels: per-channel
// capture and acknowledge, join into one word, and a show-ahead FIFO for the consumer.
module hs_join_rx_sync #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    hs_join_rx_sync_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_REQ, ST_RTZ} ch_state_e;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] req_s;

    ch_state_e       state_q [N_CH];
    ch_state_e       state_d [N_CH];
    logic [N_CH-1:0] ra_q, ra_d;
    logic [N_CH-1:0] full_q, full_d;
    logic [N_CH-1:0] slot_q, slot_d;

    logic [N_CH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic [N_CH-1:0] data_q, data_d;
    logic            push, pop;

    // Synchronizer resets high so a request left asserted across reset reads as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= bus.rr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign push  = (&full_q) && (count_q != CW'(FIFO_DEPTH));
    assign pop   = valid_q && bus.i_ready;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            state_d[k] = state_q[k];
            ra_d[k]    = ra_q[k];
            full_d[k]  = full_q[k];
            slot_d[k]  = slot_q[k];
            case (state_q[k])
                ST_REQ: begin
                    if (req_s[k] && !full_q[k]) begin
                        slot_d[k]  = bus.dat[k];
                        full_d[k]  = 1'b1;
                        ra_d[k]    = 1'b1;
                        state_d[k] = ST_RTZ;
                    end
                end
                ST_RTZ: begin
                    if (!req_s[k]) begin
                        ra_d[k]    = 1'b0;
                        state_d[k] = ST_REQ;
                    end
                end
                default: state_d[k] = ST_RTZ;
            endcase
        end
        // A join needs every slot full, so no channel can be capturing on this edge.
        if (push) full_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) state_q[k] <= ST_RTZ;
            ra_q   <= '0;
            full_q <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) state_q[k] <= state_d[k];
            ra_q   <= ra_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
        if (push) mem_q[wr_ptr_q] <= slot_q;
    end

    // Head register tracks the entry at the next read pointer, bypassing a same-edge write.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        valid_d  = (count_d != '0);
        data_d   = data_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) data_d = slot_q;
            else                                data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign bus.ra      = ra_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_count = count_q;
endmodule

// File: tb/tb_hs_join_rx_sync.sv
// Directed bench for hs_join_rx_sync: handshake timing, join, FIFO backpressure and reset.
module tb_hs_join_rx_sync;
    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    hs_join_rx_sync_if #(.N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    hs_join_rx_sync #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hs(input int ch, input logic d);
        bus.dat[ch] = d;
        bus.rr[ch]  = 1'b1;
        tick(2); chk("ra_rise_early", 32'(bus.ra[ch]), 32'd0);
        tick(1); chk("ra_rise",       32'(bus.ra[ch]), 32'd1);
        bus.rr[ch] = 1'b0;
        tick(2); chk("ra_fall_early", 32'(bus.ra[ch]), 32'd1);
        tick(1); chk("ra_fall",       32'(bus.ra[ch]), 32'd0);
    endtask

    task automatic wait_ra(input logic [3:0] exp, input string tag);
        int n = 0;
        while (bus.ra !== exp && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.ra), 32'(exp));
    endtask

    task automatic send_word(input logic [3:0] w);
        bus.dat = w;
        bus.rr  = 4'hF;
        wait_ra(4'hF, "send_ack");
        bus.rr  = 4'h0;
        wait_ra(4'h0, "send_release");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_drain [5];
        int idx;
        exp_drain = '{4'h5, 4'hA, 4'hC, 4'h6, 4'h9};

        // 1: reset with requests held high; stale requests are never captured
        rst = 1'b1; bus.rr = 4'hF; bus.dat = 4'h0; bus.i_ready = 1'b0;
        tick(2);
        chk("rst_ra",      32'(bus.ra),      32'h0);
        chk("rst_valid",   32'(bus.o_valid), 32'h0);
        chk("rst_count",   32'(bus.o_count), 32'h0);
        chk("rst_data",    32'(bus.o_data),  32'h0);
        rst = 1'b0;
        tick(6);
        chk("stale_ra",    32'(bus.ra),      32'h0);
        chk("stale_count", 32'(bus.o_count), 32'h0);
        bus.rr = 4'h0;
        tick(3);
        chk("idle_ra",     32'(bus.ra),      32'h0);

        // 2: single staggered word, dat = 1,0,1,1 on ch0..3
        hs(0, 1'b1); hs(1, 1'b0); hs(2, 1'b1); hs(3, 1'b1);
        chk("word1_valid", 32'(bus.o_valid), 32'h1);
        chk("word1_data",  32'(bus.o_data),  32'hD);
        chk("word1_count", 32'(bus.o_count), 32'h1);
        bus.i_ready = 1'b1; tick(1); bus.i_ready = 1'b0;
        chk("pop1_valid",  32'(bus.o_valid), 32'h0);
        chk("pop1_count",  32'(bus.o_count), 32'h0);
        chk("pop1_hold",   32'(bus.o_data),  32'hD);

        // 3: partial join, second ch0 token waits for ch3
        hs(0, 1'b0); hs(1, 1'b0); hs(2, 1'b0);
        chk("partial_count", 32'(bus.o_count), 32'h0);
        chk("partial_valid", 32'(bus.o_valid), 32'h0);
        bus.dat[0] = 1'b1; bus.rr[0] = 1'b1;
        tick(6);
        chk("ch0_blocked", 32'(bus.ra[0]), 32'h0);
        hs(3, 1'b1);
        chk("join2_count", 32'(bus.o_count), 32'h1);
        chk("join2_data",  32'(bus.o_data),  32'h8);
        chk("ch0_released", 32'(bus.ra[0]),  32'h1);
        bus.rr[0] = 1'b0;
        tick(3);
        chk("ch0_rtz",     32'(bus.ra[0]),   32'h0);
        hs(1, 1'b1); hs(2, 1'b1); hs(3, 1'b0);
        chk("join3_count", 32'(bus.o_count), 32'h2);
        chk("join3_head",  32'(bus.o_data),  32'h8);
        bus.i_ready = 1'b1;
        tick(1);
        chk("pop2_data",   32'(bus.o_data),  32'h7);
        chk("pop2_count",  32'(bus.o_count), 32'h1);
        tick(1);
        chk("pop3_valid",  32'(bus.o_valid), 32'h0);
        chk("pop3_count",  32'(bus.o_count), 32'h0);
        bus.i_ready = 1'b0;

        // 4: fill with i_ready low; fifth word parks in the slots, sixth is not acked
        send_word(4'h3); send_word(4'h5); send_word(4'hA); send_word(4'hC); send_word(4'h6);
        chk("full_count",  32'(bus.o_count), 32'h4);
        chk("full_head",   32'(bus.o_data),  32'h3);
        bus.dat = 4'h9; bus.rr = 4'hF;
        tick(6);
        chk("bp_ra",       32'(bus.ra),      32'h0);
        chk("bp_count",    32'(bus.o_count), 32'h4);

        // 5: one-cycle pop while full; blocked push lands on the following edge
        bus.i_ready = 1'b1; tick(1); bus.i_ready = 1'b0;
        chk("fullpop_count", 32'(bus.o_count), 32'h3);
        chk("fullpop_head",  32'(bus.o_data),  32'h5);
        tick(1);
        chk("retry_push_count", 32'(bus.o_count), 32'h4);

        // drain in order, completing the pending handshake as it is acked
        bus.i_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 80 && idx < 5; cyc++) begin
            if (bus.ra == 4'hF && bus.rr == 4'hF) bus.rr = 4'h0;
            if (bus.o_valid) begin
                chk("drain_data", 32'(bus.o_data), 32'(exp_drain[idx]));
                idx++;
            end
            tick(1);
        end
        chk("drain_words", 32'(idx), 32'd5);
        bus.i_ready = 1'b0;
        bus.rr = 4'h0;
        wait_ra(4'h0, "drain_release");
        chk("drain_count", 32'(bus.o_count), 32'h0);
        chk("drain_valid", 32'(bus.o_valid), 32'h0);

        // 6: reset mid-handshake discards FIFO and drops ra
        send_word(4'hB);
        chk("pre_rst_count", 32'(bus.o_count), 32'h1);
        bus.dat[1] = 1'b1; bus.rr[1] = 1'b1;
        tick(3);
        chk("mid_ra1",     32'(bus.ra[1]),   32'h1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_ra",    32'(bus.ra),      32'h0);
        chk("mid_rst_count", 32'(bus.o_count), 32'h0);
        chk("mid_rst_valid", 32'(bus.o_valid), 32'h0);
        chk("mid_rst_data",  32'(bus.o_data),  32'h0);
        rst = 1'b0;
        tick(5);
        chk("mid_stale_ra1", 32'(bus.ra[1]),   32'h0);
        bus.rr[1] = 1'b0;
        tick(4);
        bus.rr[1] = 1'b1;
        tick(2); chk("re_ra1_early", 32'(bus.ra[1]), 32'h0);
        tick(1); chk("re_ra1",       32'(bus.ra[1]), 32'h1);
        bus.rr[1] = 1'b0;
        tick(3); chk("re_ra1_fall",  32'(bus.ra[1]), 32'h0);
        chk("re_count", 32'(bus.o_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
